matrix_operand_loader: RTL
==========================

// Module: matrix_operand_loader
// PURPOSE
// - Upstream feeder for matrix_alu: takes one op command plus a serial stream of matrix elements.
// - Assembles the flat A and B operand vectors and holds A/B/op stable with a valid/ready handshake.
// - Lets a narrow bus (one element per beat) drive the ALU's wide parallel operand ports.
// PARAMETERS
// - word_size      8  bits per matrix element
// - Amatrixrownum  2  rows of A
// - Amatrixcolnum  2  columns of A
// - Bmatrixrownum  2  rows of B
// - Bmatrixcolnum  2  columns of B
// - Derived: NA = Amatrixrownum*Amatrixcolnum, NB = Bmatrixrownum*Bmatrixcolnum, CW = $clog2(max(NA,NB)) (min 1)
// PORTS
// - clk        in   1              clock, rising edge
// - resetn     in   1              asynchronous reset, active-low
// - cmd_valid  in   1              op command offered
// - cmd_ready  out  1              command accepted when cmd_valid&&cmd_ready
// - cmd_op     in   2              00 add, 01 sub, 10 mul, 11 kronecker
// - in_valid   in   1              element beat offered
// - in_ready   out  1              beat accepted when in_valid&&in_ready
// - in_data    in   word_size      element value
// - in_last    in   1              marks the final B element of the operand set
// - A          out  NA*word_size   element k at [k*word_size +: word_size], row-major
// - B          out  NB*word_size   same layout as A
// - op         out  2              latched cmd_op
// - mat_valid  out  1              A/B/op complete and stable
// - mat_ready  in   1              downstream consumed the operand set
// - err        out  1              one-cycle pulse on an in_last framing error
// BEHAVIOUR
// - Reset (async, resetn=0): state IDLE, cnt=0, A=0, B=0, op=2'b00, mat_valid=0, err=0, in_ready=0, cmd_ready=1.
// - All transfers occur on the rising clk edge where valid&&ready. All outputs are registered or decoded from state.
// - FSM states: IDLE, LOAD_A, LOAD_B, HOLD.
// - IDLE: cmd_ready=1, in_ready=0. On cmd accept: op<=cmd_op, cnt<=0, go to LOAD_A.
// - LOAD_A: in_ready=1, cmd_ready=0.
//   - Each beat writes A[cnt] and increments cnt.
//   - On the beat with cnt==NA-1: cnt<=0, go to LOAD_B.
// - LOAD_B: in_ready=1. Each beat writes B[cnt] and increments cnt.
//   - On the beat with cnt==NB-1 and in_last=1: go to HOLD. mat_valid=1 from the next cycle.
// - HOLD: in_ready=0, cmd_ready=0. A, B and op are frozen.
//   - On mat_ready=1: mat_valid<=0, go to IDLE.
//   - No bypass: a new command can be accepted no earlier than the cycle after mat_ready.
// - Framing errors:
//   - in_last=1 on any beat other than the final B beat, or in_last=0 on the final B beat.
//   - Response: err pulses high for 1 cycle, the set is discarded, go to IDLE, mat_valid stays 0.
//   - Partial A/B contents after an error are don't-care. op is retained.
// - Gaps: in_valid low in LOAD_A/LOAD_B stalls with no state change. There is no timeout.
// - in_valid while in IDLE or HOLD is ignored (in_ready=0).
// - Reset during any state aborts immediately to the reset values. The partial set is lost.
// - Throughput: 1 + NA + NB beats minimum, plus 1 HOLD cycle per set.
// - The downstream ALU registers C on the first clk edge where mat_valid=1; mat_ready may be asserted in that same cycle.
// STRUCTURE
// - Shared package matrix_pkg:
//   - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_KRO=2'b11.
//   - loader state typedef {IDLE, LOAD_A, LOAD_B, HOLD}.
//   - function clog2_min1.
// - Single flat module. There is no natural sub-module: the counter and element-write demux stay inline.
// - Element write: indexed part-select on cnt. No per-element enables beyond the decoded cnt.
// TESTING (default 2x2 parameters)
// - Normal load:
//   - Stimulus: cmd_op=10; beats 1,2,3,4,5,6,7,8; in_last on beat 8.
//   - Response: mat_valid=1 in the cycle after beat 8; A=32'h04030201, B=32'h08070605, op=2'b10.
// - Backpressure:
//   - Stimulus: mat_ready held low for 5 cycles in HOLD.
//   - Response: A/B/op and mat_valid stable; in_ready=0 and cmd_ready=0 throughout.
//   - After mat_ready=1: IDLE next cycle, cmd_ready=1.
// - Early in_last:
//   - Stimulus: in_last=1 on beat 3 (A[2]).
//   - Response: err=1 for exactly 1 cycle; mat_valid never rises; cmd_ready=1 the next cycle.
// - Missing in_last:
//   - Stimulus: beat 8 with in_last=0.
//   - Response: err pulse; state returns to IDLE; no mat_valid.
// - Stalled stream:
//   - Stimulus: in_valid toggles 1,0,0,1,... with a random gap pattern.
//   - Response: the same A/B as the normal load; cnt advances only on accepted beats.
// - Mid-load reset:
//   - Stimulus: resetn=0 asynchronously during LOAD_B beat 6.
//   - Response: A=0, B=0, op=00, mat_valid=0, cmd_ready=1 after release.
//   - A following full load completes correctly.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand loader and its downstream ALU:
// op encodings, the loader state type and a clog2 helper that never returns 0.
package matrix_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_KRO = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD_A = 2'b01,
        LOAD_B = 2'b10,
        HOLD   = 2'b11
    } loader_state_t;

    // Counter width helper: a single-element matrix still needs a 1-bit counter.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Command, element-stream and operand-output signals of the matrix operand loader.
// master = upstream/downstream environment, slave = the loader itself.
interface matrix_operand_loader_if #(
    parameter int word_size = 8,
    parameter int NA        = 4,
    parameter int NB        = 4
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic                      in_valid;
    logic                      in_ready;
    logic [word_size-1:0]      in_data;
    logic                      in_last;
    logic [NA*word_size-1:0]   A;
    logic [NB*word_size-1:0]   B;
    logic [1:0]                op;
    logic                      mat_valid;
    logic                      mat_ready;
    logic                      err;

    modport master (
        output cmd_valid, cmd_op, in_valid, in_data, in_last, mat_ready,
        input  cmd_ready, in_ready, A, B, op, mat_valid, err
    );

    modport slave (
        input  cmd_valid, cmd_op, in_valid, in_data, in_last, mat_ready,
        output cmd_ready, in_ready, A, B, op, mat_valid, err
    );
endinterface

// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel operand loader for matrix_alu: accepts one op command,
// then NA elements of A and NB elements of B (one per beat, in_last on the
// final B element), and holds the assembled operand set until consumed.
module matrix_operand_loader
    import matrix_pkg::*;
#(
    parameter int word_size     = 8,
    parameter int Amatrixrownum = 2,
    parameter int Amatrixcolnum = 2,
    parameter int Bmatrixrownum = 2,
    parameter int Bmatrixcolnum = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    matrix_operand_loader_if.slave    bus
);

    localparam int NA = Amatrixrownum * Amatrixcolnum;
    localparam int NB = Bmatrixrownum * Bmatrixcolnum;
    localparam int CW = clog2_min1((NA > NB) ? NA : NB);

    localparam logic [CW-1:0] A_LAST = CW'(NA - 1);
    localparam logic [CW-1:0] B_LAST = CW'(NB - 1);

    loader_state_t  state;
    loader_state_t  nxt;
    logic [CW-1:0]  cnt;
    logic           frame_err;

    // State register; reset aborts any partial set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nxt;
    end

    // Next-state and framing-error decode: in_last must appear on, and only on, the final B beat.
    always_comb begin
        nxt       = state;
        frame_err = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) nxt = LOAD_A;
            end
            LOAD_A: begin
                if (bus.in_valid) begin
                    if (bus.in_last) begin
                        frame_err = 1'b1;
                        nxt       = IDLE;
                    end else if (cnt == A_LAST) begin
                        nxt = LOAD_B;
                    end
                end
            end
            LOAD_B: begin
                if (bus.in_valid) begin
                    if (bus.in_last != (cnt == B_LAST)) begin
                        frame_err = 1'b1;
                        nxt       = IDLE;
                    end else if (cnt == B_LAST) begin
                        nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.mat_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from state.
    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.in_ready  = (state == LOAD_A) || (state == LOAD_B);
        bus.mat_valid = (state == HOLD);
    end

    // Element counter, operand assembly, op latch and the one-cycle err pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            bus.A   <= '0;
            bus.B   <= '0;
            bus.op  <= OP_ADD;
            bus.err <= 1'b0;
        end else begin
            bus.err <= frame_err;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.op <= bus.cmd_op;
                        cnt    <= '0;
                    end
                end
                LOAD_A: begin
                    if (bus.in_valid) begin
                        bus.A[cnt*word_size +: word_size] <= bus.in_data;
                        cnt <= (cnt == A_LAST) ? '0 : cnt + 1'b1;
                    end
                end
                LOAD_B: begin
                    if (bus.in_valid) begin
                        bus.B[cnt*word_size +: word_size] <= bus.in_data;
                        cnt <= (cnt == B_LAST) ? '0 : cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
